// File: rtl/alu_sequencer.sv
// Sequences single-operand-pair instructions through an external 8-bit ALU and writes results back to a 4x8 register file.
// Define ALU_SEQ_DIVZERO_TRAP_EN to trap divide-by-zero (no write-back) instead of writing 8'hFF.
module alu_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [2:0] instr_op,
    input  logic [1:0] instr_dst,
    input  logic [1:0] instr_src,
    input  logic [7:0] instr_imm,
    input  logic       instr_imm_sel,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_opr,
    output logic       alu_en,
    output logic [7:0] alu_direct,
    output logic       alu_direct_en,
    input  logic [7:0] alu_result,
    output logic       wr_valid,
    output logic [1:0] wr_dst,
    output logic [7:0] wr_data,
    output logic       flag_z,
    output logic       flag_n,
    output logic       err_div0,
    output logic       busy,
    input  logic [1:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [1:0] dbg_state
);

    // Handshake: an instruction transfers on the rising edge where instr_valid and
    // instr_ready are both 1; instr_valid while instr_ready is 0 has no effect.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_CMP = 3'd7;
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic [7:0] regs [4];
    logic [2:0] op_q;
    logic [1:0] dst_q;
    logic [7:0] a_q, b_q;
    logic       sel_q, div0_q;

    logic       accept, div0_det, cap_write;
    logic [7:0] b_sel, cap_data;

    assign accept    = instr_valid && (state == IDLE);
    assign b_sel     = instr_imm_sel ? instr_imm : regs[instr_src];
    assign div0_det  = (instr_op == OP_DIV) && (b_sel == 8'd0);
    assign rd_data   = regs[rd_addr];
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = div0_det ? CAPTURE : ISSUE;
            ISSUE:   if (cnt == SETTLE_LAST) state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        instr_ready   = (state == IDLE);
        busy          = (state != IDLE);
        alu_en        = 1'b0;
        alu_a         = '0;
        alu_b         = '0;
        alu_opr       = '0;
        alu_direct    = '0;
        alu_direct_en = 1'b0;
        wr_valid      = 1'b0;
        wr_dst        = '0;
        wr_data       = '0;
        // A divide-by-zero skips ISSUE and never enables the ALU.
        if ((state == ISSUE) || ((state == CAPTURE) && !div0_q)) begin
            alu_en  = 1'b1;
            alu_a   = a_q;
            alu_opr = (op_q == OP_CMP) ? OP_SUB : op_q;
            if (sel_q) begin
                alu_direct    = b_q;
                alu_direct_en = 1'b1;
            end else begin
                alu_b = b_q;
            end
        end
        cap_data  = div0_q ? 8'hFF : alu_result;
        cap_write = (state == CAPTURE) && (op_q != OP_CMP);
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
        cap_write = cap_write && !div0_q;
`endif
        if (cap_write) begin
            wr_valid = 1'b1;
            wr_dst   = dst_q;
            wr_data  = cap_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= '0;
            dst_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= 1'b0;
            div0_q   <= 1'b0;
            flag_z   <= 1'b0;
            flag_n   <= 1'b0;
            err_div0 <= 1'b0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            state <= state_nxt;
            if ((state == ISSUE) && (state_nxt == ISSUE)) cnt <= cnt + 4'd1;
            else cnt <= '0;
            if (accept) begin
                op_q     <= instr_op;
                dst_q    <= instr_dst;
                a_q      <= regs[instr_dst];
                b_q      <= b_sel;
                sel_q    <= instr_imm_sel;
                div0_q   <= div0_det;
                err_div0 <= div0_det;
            end
            if (cap_write) regs[dst_q] <= cap_data;
            if (state == CAPTURE) begin
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
                if (!div0_q) begin
                    flag_z <= (cap_data == 8'd0);
                    flag_n <= cap_data[7];
                end
`else
                flag_z <= (cap_data == 8'd0);
                flag_n <= cap_data[7];
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: timeline reference model for a SETTLE_CYCLES=1 instance, plus a SETTLE_CYCLES=3 back-to-back run.
module tb_alu_sequencer;

    localparam int S1 = 1;
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0, instr_valid3 = 1'b0;
    logic [2:0] instr_op = '0;
    logic [1:0] instr_dst = '0, instr_src = '0, rd_addr = '0;
    logic [7:0] instr_imm = '0;
    logic       instr_imm_sel = 1'b0;
    logic [7:0] junk = '0;

    logic       instr_ready, alu_en, alu_direct_en, wr_valid, flag_z, flag_n, err_div0, busy;
    logic [7:0] alu_a, alu_b, alu_direct, alu_result, wr_data, rd_data;
    logic [2:0] alu_opr;
    logic [1:0] wr_dst, dbg_state;

    logic       instr_ready3, alu_en3, alu_direct_en3, wr_valid3, flag_z3, flag_n3, err_div03, busy3;
    logic [7:0] alu_a3, alu_b3, alu_direct3, alu_result3, wr_data3, rd_data3;
    logic [2:0] alu_opr3;
    logic [1:0] wr_dst3, dbg_state3;

    int n_checks = 0, n_fail = 0, cyc = 0;
    int en_cnt = 0, wr_cnt = 0, last_wr_cyc = 0, acc_edge = 0;
    logic [7:0] last_wr_data = '0;

    // reference model state
    logic [7:0] m_reg [4];
    logic       m_z, m_n, m_err;
    bit         p_act, p_div0, p_sel;
    int         p_ka, p_cap;
    logic [2:0] p_op;
    logic [1:0] p_dst;
    logic [7:0] p_a, p_b, p_res;

    always #5 clk = ~clk;
    always @(posedge clk) junk <= 8'($urandom);

    function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a * b;
            3'd3: return (b == 8'd0) ? 8'hFF : a / b;
            3'd4: return a & b;
            3'd5: return a | b;
            3'd6: return a ^ b;
            default: return a - b;
        endcase
    endfunction

    assign alu_result  = alu_en  ? alu_ref(alu_opr,  alu_a,  alu_direct_en  ? alu_direct  : alu_b)  : junk;
    assign alu_result3 = alu_en3 ? alu_ref(alu_opr3, alu_a3, alu_direct_en3 ? alu_direct3 : alu_b3) : junk;

    alu_sequencer #(.SETTLE_CYCLES(S1)) u_dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_dst(instr_dst), .instr_src(instr_src), .instr_imm(instr_imm),
        .instr_imm_sel(instr_imm_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_opr(alu_opr), .alu_en(alu_en),
        .alu_direct(alu_direct), .alu_direct_en(alu_direct_en), .alu_result(alu_result),
        .wr_valid(wr_valid), .wr_dst(wr_dst), .wr_data(wr_data), .flag_z(flag_z), .flag_n(flag_n),
        .err_div0(err_div0), .busy(busy), .rd_addr(rd_addr), .rd_data(rd_data), .dbg_state(dbg_state)
    );

    alu_sequencer #(.SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid3), .instr_ready(instr_ready3),
        .instr_op(instr_op), .instr_dst(instr_dst), .instr_src(instr_src), .instr_imm(instr_imm),
        .instr_imm_sel(instr_imm_sel), .alu_a(alu_a3), .alu_b(alu_b3), .alu_opr(alu_opr3), .alu_en(alu_en3),
        .alu_direct(alu_direct3), .alu_direct_en(alu_direct_en3), .alu_result(alu_result3),
        .wr_valid(wr_valid3), .wr_dst(wr_dst3), .wr_data(wr_data3), .flag_z(flag_z3), .flag_n(flag_n3),
        .err_div0(err_div03), .busy(busy3), .rd_addr(rd_addr), .rd_data(rd_data3), .dbg_state(dbg_state3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_reg[i] = '0;
        m_z = 1'b0; m_n = 1'b0; m_err = 1'b0; p_act = 1'b0;
    endtask

    // Model: an accepted instruction spends p_cap cycles before its capture cycle, then retires.
    initial begin
        bit was_idle;
        model_clear();
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                model_clear();
            end else begin
                was_idle = !p_act;
                if (p_act && (cyc == p_ka + p_cap + 1)) begin
                    if (!(p_div0 && TRAP)) begin
                        if (p_op != 3'd7) m_reg[p_dst] = p_res;
                        m_z = (p_res == 8'd0);
                        m_n = p_res[7];
                    end
                    p_act = 1'b0;
                end
                if (was_idle && instr_valid) begin
                    p_op   = instr_op;
                    p_dst  = instr_dst;
                    p_sel  = instr_imm_sel;
                    p_a    = m_reg[instr_dst];
                    p_b    = instr_imm_sel ? instr_imm : m_reg[instr_src];
                    p_div0 = (instr_op == 3'd3) && (p_b == 8'd0);
                    p_res  = p_div0 ? 8'hFF : alu_ref(p_op, p_a, p_b);
                    p_cap  = p_div0 ? 0 : S1;
                    p_ka   = cyc;
                    p_act  = 1'b1;
                    m_err  = p_div0;
                end
            end
        end
    end

    // Compare process for u_dut, every cycle.
    initial begin
        int rel;
        logic e_en, e_wv;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_wr_valid", 32'(wr_valid), 0);
                chk("rst_alu_en", 32'(alu_en), 0);
                chk("rst_alu_bus", {alu_a, alu_b, alu_direct, 5'(alu_opr), 3'(alu_direct_en)}, 0);
                chk("rst_flags", {29'd0, flag_z, flag_n, err_div0}, 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_rd_data", 32'(rd_data), 0);
            end else begin
                rel  = cyc - p_ka;
                e_en = p_act && !p_div0;
                e_wv = p_act && (rel == p_cap) && (p_op != 3'd7) && !(p_div0 && TRAP);
                chk("instr_ready", 32'(instr_ready), 32'(!p_act));
                chk("busy", 32'(busy), 32'(p_act));
                chk("alu_en", 32'(alu_en), 32'(e_en));
                chk("alu_a", 32'(alu_a), e_en ? 32'(p_a) : 0);
                chk("alu_opr", 32'(alu_opr), e_en ? ((p_op == 3'd7) ? 32'd1 : 32'(p_op)) : 0);
                chk("alu_b", 32'(alu_b), (e_en && !p_sel) ? 32'(p_b) : 0);
                chk("alu_direct", 32'(alu_direct), (e_en && p_sel) ? 32'(p_b) : 0);
                chk("alu_direct_en", 32'(alu_direct_en), 32'(e_en && p_sel));
                chk("wr_valid", 32'(wr_valid), 32'(e_wv));
                if (e_wv) begin
                    chk("wr_dst", 32'(wr_dst), 32'(p_dst));
                    chk("wr_data", 32'(wr_data), 32'(p_res));
                end
                chk("flag_z", 32'(flag_z), 32'(m_z));
                chk("flag_n", 32'(flag_n), 32'(m_n));
                chk("err_div0", 32'(err_div0), 32'(m_err));
                chk("rd_data", 32'(rd_data), 32'(m_reg[rd_addr]));
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (alu_en) en_cnt++;
            if (wr_valid) begin
                wr_cnt++;
                last_wr_data = wr_data;
                last_wr_cyc  = cyc;
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] src,
                        input logic [7:0] imm, input logic sel);
        bit got = 1'b0;
        @(posedge clk); #1;
        instr_op = op; instr_dst = dst; instr_src = src; instr_imm = imm; instr_imm_sel = sel;
        instr_valid = 1'b1;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            if (instr_ready) begin
                @(posedge clk);
                got = 1'b1;
            end
        end
        if (!got) chk("accept_timeout", 32'(got), 1);
        #1;
        instr_valid = 1'b0;
        acc_edge = cyc;
    endtask

    task automatic wait_done();
        int t = 0;
        @(negedge clk);
        while (p_act && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (p_act) chk("done_timeout", 32'(p_act), 0);
    endtask

    task automatic peek(input logic [1:0] a, input logic [7:0] e, input string nm);
        @(posedge clk); #1;
        rd_addr = a;
        @(negedge clk);
        chk(nm, 32'(rd_data), 32'(e));
    endtask

    task automatic run_b2b();
        @(posedge clk); #1;
        instr_op = 3'd0; instr_dst = 2'd0; instr_src = 2'd0; instr_imm = 8'd1; instr_imm_sel = 1'b1;
        instr_valid3 = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("b2b_ready", 32'(instr_ready3), 32'(i % 5 == 4));
            chk("b2b_alu_en", 32'(alu_en3), 32'(i % 5 <= 3));
            chk("b2b_wr_valid", 32'(wr_valid3), 32'(i % 5 == 3));
            if (i % 5 == 3) chk("b2b_wr_data", 32'(wr_data3), 32'(i / 5 + 1));
        end
        @(posedge clk); #1;
        instr_valid3 = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_r3;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", 32'(instr_ready), 1);
        chk("reset_flag_z", 32'(flag_z), 0);
        chk("reset_err", 32'(err_div0), 0);

        en_cnt = 0; wr_cnt = 0;
        send(3'd0, 2'd0, 2'd0, 8'h05, 1'b1);
        wait_done();
        chk("add_en_cycles", 32'(en_cnt), 2);
        chk("add_wr_count", 32'(wr_cnt), 1);
        chk("add_latency", 32'(last_wr_cyc - acc_edge), 1);
        chk("add_wr_data", 32'(last_wr_data), 32'h05);
        chk("add_flag_z", 32'(flag_z), 0);
        peek(2'd0, 8'h05, "add_r0");

        send(3'd4, 2'd0, 2'd0, 8'h00, 1'b1);
        send(3'd5, 2'd0, 2'd0, 8'hF0, 1'b1);
        send(3'd2, 2'd0, 2'd0, 8'h10, 1'b1);
        wait_done();
        chk("mul_wr_data", 32'(last_wr_data), 0);
        chk("mul_flag_z", 32'(flag_z), 1);
        chk("mul_flag_n", 32'(flag_n), 0);

        send(3'd4, 2'd1, 2'd0, 8'h00, 1'b1);
        send(3'd5, 2'd1, 2'd0, 8'h03, 1'b1);
        send(3'd4, 2'd2, 2'd0, 8'h00, 1'b1);
        send(3'd5, 2'd2, 2'd0, 8'h07, 1'b1);
        wait_done();
        wr_cnt = 0;
        send(3'd7, 2'd1, 2'd2, 8'h00, 1'b0);
        @(negedge clk);
        chk("cmp_alu_opr", 32'(alu_opr), 1);
        wait_done();
        chk("cmp_wr_count", 32'(wr_cnt), 0);
        chk("cmp_flag_n", 32'(flag_n), 1);
        chk("cmp_flag_z", 32'(flag_z), 0);
        peek(2'd1, 8'h03, "cmp_r1");

        en_cnt = 0;
        exp_r3 = TRAP ? 8'h00 : 8'hFF;
        send(3'd3, 2'd3, 2'd0, 8'h00, 1'b1);
        wait_done();
        chk("div0_en_cycles", 32'(en_cnt), 0);
        chk("div0_err", 32'(err_div0), 1);
        peek(2'd3, exp_r3, "div0_r3");
        send(3'd0, 2'd3, 2'd0, 8'h01, 1'b1);
        wait_done();
        chk("div0_err_cleared", 32'(err_div0), 0);

        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            instr_valid   = ($urandom_range(0, 1) == 1);
            instr_op      = 3'($urandom_range(0, 7));
            instr_dst     = 2'($urandom_range(0, 3));
            instr_src     = 2'($urandom_range(0, 3));
            instr_imm     = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            instr_imm_sel = ($urandom_range(0, 1) == 1);
            rd_addr       = 2'($urandom_range(0, 3));
        end
        @(posedge clk); #1;
        instr_valid = 1'b0;
        wait_done();

        send(3'd5, 2'd0, 2'd0, 8'h81, 1'b1);
        wait_done();
        wr_cnt = 0;
        send(3'd1, 2'd0, 2'd1, 8'h03, 1'b1);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", 32'(instr_ready), 1);
        chk("rst_mid_wr_count", 32'(wr_cnt), 0);
        peek(2'd0, 8'h00, "rst_mid_r0");

        run_b2b();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 1, meaning cycles alu_en is held (range 1..15) before alu_result is sampled.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports instr_valid input 1 and instr_ready output 1: instruction handshake.
REQ-005 SHALL have ports instr_op input 3 (0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 CMP), instr_dst input 2, instr_src input 2, instr_imm input 8, instr_imm_sel input 1.
REQ-006 SHALL have ports alu_a output 8, alu_b output 8, alu_opr output 3, alu_en output 1, alu_direct output 8, alu_direct_en output 1: ALU operand/control side.
REQ-007 SHALL have port alu_result input 8: ALU output bus, high-Z when ALU disabled.
REQ-008 SHALL have ports wr_valid output 1, wr_dst output 2, wr_data output 8: write-back report.
REQ-009 SHALL have ports flag_z output 1, flag_n output 1, err_div0 output 1, busy output 1.
REQ-010 SHALL have ports rd_addr input 2, rd_data output 8: combinational read of internal register file.

Function
REQ-011 SHALL contain a 4x8 register file r0..r3; operand A = r[instr_dst], operand B = instr_imm if instr_imm_sel else r[instr_src].
REQ-012 SHALL implement FSM IDLE -> ISSUE -> CAPTURE -> IDLE; instr_ready = 1 only in IDLE; busy = not IDLE.
REQ-013 SHALL latch op, dst, A, B and imm_sel on the edge where instr_valid and instr_ready are both 1; instr_valid while not ready is ignored.
REQ-014 In ISSUE, SHALL drive alu_en=1, alu_a=A, alu_opr=op (SUB when op is CMP); when imm_sel, alu_direct=imm, alu_direct_en=1 and alu_b=0; otherwise alu_b=B, alu_direct_en=0.
REQ-015 SHALL remain in ISSUE exactly SETTLE_CYCLES cycles (internal 4-bit counter), then enter CAPTURE.
REQ-016 In CAPTURE, SHALL keep alu_en=1, sample alu_result, pulse wr_valid for exactly one cycle with wr_dst=dst, wr_data=sample, and write r[dst] at the end of that cycle (op 0-6 only).
REQ-017 For CMP, wr_valid SHALL stay 0 and r[dst] SHALL be unchanged; flags update only.
REQ-018 On every CAPTURE (incl. CMP), flag_z SHALL become (sample==0) and flag_n SHALL become sample[7]; otherwise flags hold.
REQ-019 Results SHALL be the low 8 bits (MUL truncated, ADD/SUB wrap modulo 256).
REQ-020 Outside ISSUE/CAPTURE, alu_en, alu_direct_en SHALL be 0 and alu_a, alu_b, alu_direct, alu_opr SHALL be 0.
REQ-021 Accept-to-wr_valid latency SHALL be SETTLE_CYCLES+1 cycles; instr_ready returns 1 the cycle after CAPTURE; throughput one instruction per SETTLE_CYCLES+2 cycles.
REQ-022 A write to rd_addr's register SHALL be visible on rd_data the cycle after wr_valid.
REQ-023 DIV with B==0 SHALL be detected at accept; ISSUE is skipped (alu_en stays 0) and FSM goes directly to CAPTURE; handling per REQ-028/029.
REQ-024 err_div0 SHALL be sticky, cleared only when a non-div-by-zero instruction is accepted.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, counter 0, r0..r3=0, flags 0, err_div0=0, wr_valid=0, alu_en=0, all ALU outputs 0, instr_ready=1 after release.
REQ-026 Reset mid-ISSUE or mid-CAPTURE SHALL abandon the instruction with no register write and no wr_valid pulse.

Configuration
REQ-027 Macro ALU_SEQ_DIVZERO_TRAP_EN SHALL select div-by-zero handling.
REQ-028 With ALU_SEQ_DIVZERO_TRAP_EN defined: div-by-zero sets err_div0=1, no wr_valid, r[dst] and flags unchanged.
REQ-029 Without it: div-by-zero writes 8'hFF to r[dst] with wr_valid pulse, flag_z=0, flag_n=1, err_div0 still set.

Verification
REQ-030 Reset, then ADD imm 8'h05 to r0 (SETTLE=1) -> alu_en high 2 cycles, wr_valid at accept+2, wr_data=8'h05, r0=5, flag_z=0.
REQ-031 r0=8'hF0, MUL by imm 8'h10 -> wr_data=8'h00, flag_z=1, flag_n=0.
REQ-032 r1=8'h03, r2=8'h07, CMP dst=r1 src=r2 -> no wr_valid, r1=3, flag_n=1, flag_z=0, alu_opr=1 during ISSUE.
REQ-033 DIV r3 by imm 0, both macro settings -> alu_en never asserted, err_div0=1; trap: r3 unchanged; no-trap: r3=8'hFF; next ADD clears err_div0.
REQ-034 SETTLE_CYCLES=3, back-to-back instr_valid held high -> accepts spaced 5 cycles, each wr_valid single-cycle.
REQ-035 Assert rst_n low during ISSUE of SUB r0 -> no wr_valid, r0=0, instr_ready=1 after release.
